// File: rtl/spi_master_ctl.sv
// SPI mode-0 master: shifts DATA_W-bit words out MSB-first on mosi inside one cs_n frame
// and captures the word returned on miso.
module spi_master_ctl #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_GAP   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              busy_o,
   output logic              sck_o,
   output logic              cs_n_o,
   output logic              mosi_o,
   input  logic              miso_i
);

   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W    = $clog2(DATA_W) + 1;
   localparam int unsigned WAIT_MAX = (CS_SETUP > CS_HOLD) ?
                                      ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                                      ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
   localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_HOLD,
      ST_GAP
   } state_e;

   state_e              state_q, state_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                sck_q, sck_d;
   logic                cs_n_q, cs_n_d;
   logic                tx_ready_q, tx_ready_d;
   logic                busy_q, busy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         wait_cnt_q <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sck_q      <= sck_d;
         cs_n_q     <= cs_n_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
      end
   end

   // Frame sequencing; mosi is the MSB of the transmit shift register.
   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      wait_cnt_d = wait_cnt_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sck_d      = sck_q;
      cs_n_d     = cs_n_q;

      case (state_q)
         ST_IDLE: begin
            if (tx_valid_i && tx_ready_q) begin
               tx_sh_d    = tx_data_i;
               rx_sh_d    = '0;
               cs_n_d     = 1'b0;
               wait_cnt_d = '0;
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (wait_cnt_q == WAIT_W'(CS_SETUP - 1)) begin
               wait_cnt_d = '0;
               div_cnt_d  = '0;
               bit_cnt_d  = '0;
               sck_d      = 1'b1;
               state_d    = ST_XFER;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_XFER: begin
            if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
               div_cnt_d = '0;
               if (sck_q) begin
                  // Falling edge: capture miso, advance mosi except after the last bit.
                  sck_d     = 1'b0;
                  rx_sh_d   = {rx_sh_q[DATA_W-2:0], miso_i};
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  if (bit_cnt_q != BIT_W'(DATA_W - 1)) begin
                     tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                  end
               end else if (bit_cnt_q == BIT_W'(DATA_W)) begin
                  wait_cnt_d = '0;
                  state_d    = ST_HOLD;
               end else begin
                  sck_d = 1'b1;
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         ST_HOLD: begin
            if (wait_cnt_q == WAIT_W'(CS_HOLD - 1)) begin
               wait_cnt_d = '0;
               cs_n_d     = 1'b1;
               tx_sh_d    = '0;
               rx_data_d  = rx_sh_q;
               rx_valid_d = 1'b1;
               state_d    = ST_GAP;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_GAP: begin
            if (wait_cnt_q == WAIT_W'(CS_GAP - 1)) begin
               wait_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      tx_ready_d = (state_d == ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
   end

   assign tx_ready_o = tx_ready_q;
   assign busy_o     = busy_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign sck_o      = sck_q;
   assign cs_n_o     = cs_n_q;
   assign mosi_o     = tx_sh_q[DATA_W-1];

endmodule

// File: tb/tb_spi_master_ctl.sv
// Randomized self-checking bench for spi_master_ctl against a frame-level reference model.
module tb_spi_master_ctl;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned CLK_DIV  = 4;
   localparam int unsigned CS_SETUP = 2;
   localparam int unsigned CS_HOLD  = 2;
   localparam int unsigned CS_GAP   = 2;
   localparam int FRAME_LOW    = CS_SETUP + 2 * DATA_W * CLK_DIV + CS_HOLD;
   localparam int FRAME_PERIOD = FRAME_LOW + CS_GAP + 1;

   typedef struct {
      int                low;
      int                rises;
      logic [DATA_W-1:0] mosi;
      int                viol;
      logic              rv;
      logic [DATA_W-1:0] rxd;
      int                start;
      int                stop;
   } frame_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] tx_data = '0;
   logic              tx_valid = 1'b0;
   logic              tx_ready, rx_valid, busy, sck, cs_n, mosi, miso;
   logic [DATA_W-1:0] rx_data;

   logic              loop_en = 1'b1;
   logic              sl_bit = 1'b0;
   logic [DATA_W-1:0] sl_word = '0;

   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   int     rv_cnt = 0;
   int     ready_delay = -1;
   int     last_stop = 0;
   int     frames_done = 0;
   frame_t fq[$];
   frame_t cur;
   bit     in_frame = 1'b0;
   logic [DATA_W-1:0] last_rx = '0;

   spi_master_ctl #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .CS_GAP  (CS_GAP)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_data_i (tx_data),
      .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready),
      .rx_data_o (rx_data),
      .rx_valid_o(rx_valid),
      .busy_o    (busy),
      .sck_o     (sck),
      .cs_n_o    (cs_n),
      .mosi_o    (mosi),
      .miso_i    (miso)
   );

   always #5 clk = ~clk;

   assign miso = loop_en ? mosi : sl_bit;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Frame observer plus a mode-0 slave that presents its MSB at cs_n fall and shifts on sck fall.
   initial begin
      int sl_idx;
      logic p_sck, p_cs, p_rdy;
      sl_idx = 0; p_sck = 1'b0; p_cs = 1'b1; p_rdy = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (rx_valid) rv_cnt++;
         if (!rst_n) begin
            in_frame = 1'b0;
            p_sck = 1'b0; p_cs = 1'b1; p_rdy = 1'b1;
            sl_idx = 0;
         end else begin
            if (p_cs && !cs_n) begin
               in_frame = 1'b1;
               cur.low = 0; cur.rises = 0; cur.mosi = '0; cur.viol = 0;
               cur.rv = 1'b0; cur.rxd = '0; cur.start = cyc; cur.stop = 0;
               sl_idx = 0;
            end
            if (in_frame && !cs_n) begin
               cur.low = cur.low + 1;
               if (tx_ready || !busy) cur.viol = cur.viol + 1;
            end
            if (in_frame && !p_sck && sck) begin
               cur.rises = cur.rises + 1;
               cur.mosi  = {cur.mosi[DATA_W-2:0], mosi};
            end
            if (p_sck && !sck) sl_idx++;
            if (in_frame && !p_cs && cs_n) begin
               cur.rv = rx_valid; cur.rxd = rx_data; cur.stop = cyc;
               fq.push_back(cur);
               in_frame = 1'b0;
               last_stop = cyc;
            end
            if (!p_rdy && tx_ready) ready_delay = cyc - last_stop;
            p_sck = sck; p_cs = cs_n; p_rdy = tx_ready;
         end
         sl_bit = (sl_idx < int'(DATA_W)) ? sl_word[DATA_W-1-sl_idx] : 1'b0;
      end
   end

   task automatic send(input logic [DATA_W-1:0] w, input bit keep_valid);
      int n;
      n = 0;
      tx_data  = w;
      tx_valid = 1'b1;
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("accept_timeout", 32'd0, 32'd1);
      @(negedge clk);
      if (!keep_valid) begin
         tx_valid = 1'b0;
         tx_data  = DATA_W'($urandom);
      end
   endtask

   task automatic get_frame(output frame_t f, output bit ok);
      int n;
      n = 0;
      while (fq.size() == 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      ok = (fq.size() != 0);
      if (ok) f = fq.pop_front();
      else check("frame_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_frame(input logic [DATA_W-1:0] exp_tx, input logic [DATA_W-1:0] exp_rx,
                              output frame_t f);
      bit ok;
      get_frame(f, ok);
      if (ok) begin
         check("cs_low_cycles", 32'(f.low), 32'(FRAME_LOW));
         check("sck_rises", 32'(f.rises), 32'(DATA_W));
         check("mosi_bits", 32'(f.mosi), 32'(exp_tx));
         check("ready_busy_in_frame", 32'(f.viol), 32'd0);
         check("rx_valid_at_cs_rise", 32'(f.rv), 32'd1);
         check("rx_data", 32'(f.rxd), 32'(exp_rx));
         frames_done++;
         last_rx = exp_rx;
      end
   endtask

   initial begin
      frame_t f1, f2;
      logic [DATA_W-1:0] w;
      int n, rv_before;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_cs_n", 32'(cs_n), 32'd1);
      check("post_rst_sck", 32'(sck), 32'd0);
      check("post_rst_no_rx_valid", 32'(rv_cnt), 32'd0);

      // Loopback frame
      loop_en = 1'b1;
      send(16'hA53C, 1'b0);
      check_frame(16'hA53C, 16'hA53C, f1);

      // Slave-driven response
      loop_en = 1'b0;
      sl_word = 16'h1234;
      w = DATA_W'($urandom);
      send(w, 1'b0);
      check_frame(w, 16'h1234, f1);

      // Back-to-back with tx_valid held high
      loop_en = 1'b1;
      repeat (3) @(negedge clk);
      send(16'h0001, 1'b1);
      send(16'hFFFF, 1'b0);
      check_frame(16'h0001, 16'h0001, f1);
      check("tx_ready_return", 32'(ready_delay), 32'(CS_GAP));
      check_frame(16'hFFFF, 16'hFFFF, f2);
      check("b2b_period", 32'(f2.start - f1.start), 32'(FRAME_PERIOD));
      check("b2b_gap_min", 32'(f2.start - f1.stop >= int'(CS_GAP)), 32'd1);

      // Reset after the 7th sck rise
      repeat (4) @(negedge clk);
      rv_before = rv_cnt;
      send(DATA_W'($urandom), 1'b0);
      n = 0;
      while (!(in_frame && cur.rises >= 7) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("mid_wait_7_rises", 32'(cur.rises), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_cs_n", 32'(cs_n), 32'd1);
      check("mid_rst_sck", 32'(sck), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_no_rx_valid", 32'(rv_cnt - rv_before), 32'd0);
      check("mid_rst_no_frame", 32'(fq.size()), 32'd0);
      check("mid_rst_rx_data_cleared", 32'(rx_data), 32'd0);
      send(16'h00FF, 1'b0);
      check_frame(16'h00FF, 16'h00FF, f1);
      rv_before = rv_cnt - frames_done + 0;

      // Randomized frames against the model
      for (int i = 0; i < 6; i++) begin
         loop_en = 1'($urandom_range(0, 1));
         sl_word = DATA_W'($urandom);
         w       = DATA_W'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send(w, 1'b0);
         check_frame(w, loop_en ? w : sl_word, f1);
      end

      // rx_data holds between frames; one rx_valid cycle per completed frame
      tx_data = DATA_W'($urandom);
      repeat (20) @(negedge clk);
      check("rx_data_held", 32'(rx_data), 32'(last_rx));
      check("rx_valid_pulses", 32'(rv_cnt), 32'(frames_done));
      check("idle_cs_n", 32'(cs_n), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
